// File: rtl/mandelbrot_scan.sv
// Mandelbrot frame scanner: walks a width x height grid in raster order,
// hands each point to an external engine and streams back one pixel per point.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a frame (sampled only when idle)
//   x_min, y_max, step  signed Q3.29 origin (column 0 / row 0) and pixel pitch
//   img_width/height    frame dimensions in pixels
//   max_iterations      iteration limit, latched and forwarded to the engine
//   pt_req/pt_ack       point request handshake, pt_x/pt_y coordinates
//   pt_max_iterations   latched iteration limit for the engine
//   pt_done             one-cycle result pulse with pt_iteration_count
//   pix_valid/ready     pixel stream handshake
//   pix_col/row/iters   pixel payload
//   busy, frame_done    frame in progress, one-cycle end-of-frame pulse
module mandelbrot_scan #(
  parameter int DIM_BITS = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         x_min,
  input  logic [31:0]         y_max,
  input  logic [31:0]         step,
  input  logic [DIM_BITS-1:0] img_width,
  input  logic [DIM_BITS-1:0] img_height,
  input  logic [31:0]         max_iterations,
  output logic                pt_req,
  input  logic                pt_ack,
  output logic [31:0]         pt_x,
  output logic [31:0]         pt_y,
  output logic [31:0]         pt_max_iterations,
  input  logic                pt_done,
  input  logic [9:0]          pt_iteration_count,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [DIM_BITS-1:0] pix_col,
  output logic [DIM_BITS-1:0] pix_row,
  output logic [9:0]          pix_iterations,
  output logic                busy,
  output logic                frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]         x_min_q;
  logic [31:0]         step_q;
  logic [DIM_BITS-1:0] width_q;
  logic [DIM_BITS-1:0] height_q;
  logic [DIM_BITS-1:0] col;
  logic [DIM_BITS-1:0] row;

  logic dims_zero;
  logic launch;
  logic xfer;
  logic row_end;
  logic last_pix;

  // A zero-sized frame completes immediately without touching the engine.
  assign dims_zero = (img_width == '0) || (img_height == '0);
  assign launch    = (state == IDLE) && start;
  assign xfer      = (state == EMIT) && pix_ready;
  assign row_end   = (col == width_q - DIM_BITS'(1));
  assign last_pix  = row_end && (row == height_q - DIM_BITS'(1));

  assign pt_req    = (state == ISSUE);
  assign pix_valid = (state == EMIT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && !dims_zero) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (pt_ack) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (pt_done) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (pix_ready) begin
          state_nxt = last_pix ? IDLE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_min_q           <= '0;
      step_q            <= '0;
      width_q           <= '0;
      height_q          <= '0;
      col               <= '0;
      row               <= '0;
      pt_x              <= '0;
      pt_y              <= '0;
      pt_max_iterations <= '0;
      pix_col           <= '0;
      pix_row           <= '0;
      pix_iterations    <= '0;
      frame_done        <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (launch) begin
        if (dims_zero) begin
          frame_done <= 1'b1;
        end else begin
          x_min_q           <= x_min;
          step_q            <= step;
          width_q           <= img_width;
          height_q          <= img_height;
          col               <= '0;
          row               <= '0;
          pt_x              <= x_min;
          pt_y              <= y_max;
          pt_max_iterations <= max_iterations;
        end
      end

      if ((state == WAIT) && pt_done) begin
        pix_iterations <= pt_iteration_count;
        pix_col        <= col;
        pix_row        <= row;
      end

      // Coordinates step incrementally; wrap-around is intentional.
      if (xfer) begin
        if (!row_end) begin
          col  <= col + DIM_BITS'(1);
          pt_x <= pt_x + step_q;
        end else if (!last_pix) begin
          col  <= '0;
          row  <= row + DIM_BITS'(1);
          pt_x <= x_min_q;
          pt_y <= pt_y - step_q;
        end else begin
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_scan.sv
// Directed bench for mandelbrot_scan with a stub point engine
// and a stalling pixel sink.
module tb_mandelbrot_scan;

  localparam int DB = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   x_min;
  logic [31:0]   y_max;
  logic [31:0]   step;
  logic [DB-1:0] img_width;
  logic [DB-1:0] img_height;
  logic [31:0]   max_iterations;
  logic          pt_req;
  logic          pt_ack;
  logic [31:0]   pt_x;
  logic [31:0]   pt_y;
  logic [31:0]   pt_max_iterations;
  logic          pt_done;
  logic [9:0]    pt_iteration_count;
  logic          pix_valid;
  logic          pix_ready;
  logic [DB-1:0] pix_col;
  logic [DB-1:0] pix_row;
  logic [9:0]    pix_iterations;
  logic          busy;
  logic          frame_done;

  mandelbrot_scan #(.DIM_BITS(DB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_min(x_min), .y_max(y_max), .step(step),
    .img_width(img_width), .img_height(img_height),
    .max_iterations(max_iterations),
    .pt_req(pt_req), .pt_ack(pt_ack),
    .pt_x(pt_x), .pt_y(pt_y),
    .pt_max_iterations(pt_max_iterations),
    .pt_done(pt_done), .pt_iteration_count(pt_iteration_count),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_col(pix_col), .pix_row(pix_row),
    .pix_iterations(pix_iterations),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0]   px [16];
  logic [31:0]   py [16];
  logic [31:0]   pmi[16];
  logic [DB-1:0] pc [16];
  logic [DB-1:0] pr [16];
  logic [9:0]    pit[16];
  int n_pts, n_pix, fd_cnt, busy_cnt, req_cnt, req_in_emit;
  int stall_seen, stall_bad;
  int lat = 3;
  int res_base = 10;
  int stall_cycles = 0;
  int hold_left = 0;
  int eng_cnt;
  logic [31:0] hold_pl;
  logic [31:0] payload;

  assign payload = {pix_col, pix_row, pix_iterations};

  // stub point engine: ack at once, pt_done lat cycles later
  initial begin
    pt_ack = 1'b0;
    pt_done = 1'b0;
    pt_iteration_count = '0;
    eng_cnt = 0;
    forever begin
      @(negedge clk);
      pt_ack = 1'b0;
      pt_done = 1'b0;
      if (reset) begin
        eng_cnt = 0;
      end else if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          pt_done = 1'b1;
          pt_iteration_count = 10'(res_base + n_pts - 1);
        end
      end else if (pt_req) begin
        pt_ack = 1'b1;
        if (n_pts < 16) begin
          px[n_pts]  = pt_x;
          py[n_pts]  = pt_y;
          pmi[n_pts] = pt_max_iterations;
        end
        n_pts++;
        eng_cnt = lat;
      end
    end
  end

  // pixel sink and activity monitor
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (busy) busy_cnt++;
      if (pt_req) req_cnt++;
      if (pt_req && pix_valid) req_in_emit++;
      pix_ready = 1'b1;
      if (pix_valid) begin
        if (hold_left > 0) begin
          pix_ready = 1'b0;
          if (hold_left == stall_cycles) hold_pl = payload;
          else if (payload !== hold_pl) stall_bad++;
          stall_seen++;
          hold_left--;
        end else begin
          if (stall_cycles > 0 && payload !== hold_pl) stall_bad++;
          if (n_pix < 16) begin
            pc[n_pix]  = pix_col;
            pr[n_pix]  = pix_row;
            pit[n_pix] = pix_iterations;
          end
          n_pix++;
          hold_left = stall_cycles;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    n_pts = 0; n_pix = 0; fd_cnt = 0; busy_cnt = 0;
    req_cnt = 0; req_in_emit = 0; stall_seen = 0; stall_bad = 0;
  endtask

  task automatic setup(input logic [31:0] xm, input logic [31:0] ym,
                       input logic [31:0] st, input int w, input int h,
                       input logic [31:0] mi);
    x_min = xm; y_max = ym; step = st;
    img_width = DB'(w); img_height = DB'(h);
    max_iterations = mi;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    for (int i = 0; i < budget && fd_cnt == 0; i++) @(negedge clk);
    check("frame_timeout", 64'(fd_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  logic [31:0] ex[4];
  logic [31:0] ey[4];
  int          ec[4];
  int          er[4];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    setup(32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    clear_logs();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pt_req", 64'(pt_req), 64'd0);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_pix_col", 64'(pix_col), 64'd0);
    check("rst_pix_row", 64'(pix_row), 64'd0);
    check("rst_pix_iter", 64'(pix_iterations), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();

    // 2x2 frame, inputs disturbed and start re-pulsed mid-frame
    lat = 3; res_base = 10; stall_cycles = 0; hold_left = 0;
    setup(32'hC000_0000, 32'h2000_0000, 32'h1000_0000, 2, 2, 32'd100);
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    setup(32'h1234_5678, 32'h0, 32'h0100_0000, 5, 5, 32'd55);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("maxit_mid", 64'(pt_max_iterations), 64'd100);
    wait_frame(300);
    ex = '{32'hC000_0000, 32'hD000_0000, 32'hC000_0000, 32'hD000_0000};
    ey = '{32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000};
    ec = '{0, 1, 0, 1};
    er = '{0, 0, 1, 1};
    check("a_points", 64'(n_pts), 64'd4);
    check("a_pixels", 64'(n_pix), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("a_x%0d", i), 64'(px[i]), 64'(ex[i]));
      check($sformatf("a_y%0d", i), 64'(py[i]), 64'(ey[i]));
      check($sformatf("a_mi%0d", i), 64'(pmi[i]), 64'd100);
      check($sformatf("a_col%0d", i), 64'(pc[i]), 64'(ec[i]));
      check($sformatf("a_row%0d", i), 64'(pr[i]), 64'(er[i]));
      check($sformatf("a_it%0d", i), 64'(pit[i]), 64'(10 + i));
    end
    check("a_frame_done", 64'(fd_cnt), 64'd1);
    check("a_req_cycles", 64'(req_cnt), 64'd4);
    check("a_busy_end", 64'(busy), 64'd0);
    check("a_maxit_end", 64'(pt_max_iterations), 64'd100);
    clear_logs();

    // 1x1 frame, 5-cycle engine, sink stalls 4 cycles
    lat = 5; res_base = 37; stall_cycles = 4; hold_left = 4;
    setup(32'h0, 32'h0, 32'h1000_0000, 1, 1, 32'd9);
    pulse_start();
    wait_frame(200);
    check("s_pixels", 64'(n_pix), 64'd1);
    check("s_iter", 64'(pit[0]), 64'd37);
    check("s_stall_cycles", 64'(stall_seen), 64'd4);
    check("s_stall_unstable", 64'(stall_bad), 64'd0);
    check("s_req_in_emit", 64'(req_in_emit), 64'd0);
    check("s_req_cycles", 64'(req_cnt), 64'd1);
    check("s_busy_cycles", 64'(busy_cnt), 64'd11);
    check("s_frame_done", 64'(fd_cnt), 64'd1);
    stall_cycles = 0; hold_left = 0;
    clear_logs();

    // zero-sized frames
    setup(32'h0, 32'h0, 32'h1000_0000, 0, 3, 32'd9);
    pulse_start();
    repeat (4) @(negedge clk);
    check("z_frame_done", 64'(fd_cnt), 64'd1);
    check("z_busy", 64'(busy_cnt), 64'd0);
    check("z_req", 64'(req_cnt), 64'd0);
    check("z_pixels", 64'(n_pix), 64'd0);
    clear_logs();
    setup(32'h0, 32'h0, 32'h1000_0000, 2, 0, 32'd9);
    pulse_start();
    repeat (4) @(negedge clk);
    check("zh_frame_done", 64'(fd_cnt), 64'd1);
    check("zh_busy", 64'(busy_cnt), 64'd0);
    clear_logs();

    // reset while waiting on the engine
    lat = 8; res_base = 10;
    setup(32'hC000_0000, 32'h2000_0000, 32'h1000_0000, 2, 2, 32'd77);
    pulse_start();
    @(negedge clk);
    check("w_in_wait", 64'({busy, pt_req, pix_valid}), 64'b100);
    check("w_acked", 64'(n_pts), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("w_pt_req", 64'(pt_req), 64'd0);
    check("w_pix_valid", 64'(pix_valid), 64'd0);
    check("w_busy", 64'(busy), 64'd0);
    check("w_frame_done", 64'(frame_done), 64'd0);
    check("w_pix", 64'(payload), 64'd0);
    check("w_pt_xy", {pt_x, pt_y}, 64'd0);
    check("w_maxit", 64'(pt_max_iterations), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("w_no_frame_done", 64'(fd_cnt), 64'd0);
    clear_logs();

    // fresh frame after reset; coordinates wrap both ways
    lat = 2; res_base = 20;
    setup(32'h7000_0000, 32'h8000_0000, 32'h1000_0000, 2, 2, 32'd5);
    pulse_start();
    wait_frame(300);
    ex = '{32'h7000_0000, 32'h8000_0000, 32'h7000_0000, 32'h8000_0000};
    ey = '{32'h8000_0000, 32'h8000_0000, 32'h7000_0000, 32'h7000_0000};
    check("r_points", 64'(n_pts), 64'd4);
    check("r_pixels", 64'(n_pix), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("r_xy%0d", i), {px[i], py[i]}, {ex[i], ey[i]});
      check($sformatf("r_cr%0d", i), 64'({pc[i], pr[i]}),
            64'({DB'(ec[i]), DB'(er[i])}));
      check($sformatf("r_it%0d", i), 64'(pit[i]), 64'(20 + i));
    end
    check("r_frame_done", 64'(fd_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mandelbrot_scan.md
MANDELBROT_SCAN -- requirements
Module: mandelbrot_scan

Interface
REQ-001 SHALL have parameter DIM_BITS, default 11, width of image dimension and pixel-index signals.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a frame; sampled only in IDLE.
REQ-005 SHALL have port x_min  input  32  signed Q3.29 real coordinate of column 0.
REQ-006 SHALL have port y_max  input  32  signed Q3.29 imaginary coordinate of row 0.
REQ-007 SHALL have port step  input  32  signed Q3.29 pixel pitch.
REQ-008 SHALL have port img_width  input  DIM_BITS  columns per row.
REQ-009 SHALL have port img_height  input  DIM_BITS  rows per frame.
REQ-010 SHALL have port max_iterations  input  32  iteration limit forwarded to the point engine.
REQ-011 SHALL have port pt_req  output  1  request to the point engine.
REQ-012 SHALL have port pt_ack  input  1  point engine accepted the request.
REQ-013 SHALL have ports pt_x and pt_y  output  32 each  signed Q3.29 point coordinates.
REQ-014 SHALL have port pt_max_iterations  output  32  latched iteration limit.
REQ-015 SHALL have port pt_done  input  1  one-cycle completion pulse from the point engine.
REQ-016 SHALL have port pt_iteration_count  input  10  result, valid with pt_done.
REQ-017 SHALL have ports pix_valid  output  1, and pix_ready  input  1  pixel stream handshake.
REQ-018 SHALL have ports pix_col and pix_row  output  DIM_BITS each, and pix_iterations  output  10  pixel payload.
REQ-019 SHALL have ports busy  output  1  frame in progress, and frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, EMIT.
REQ-021 In IDLE with start=1: latch x_min, y_max, step, img_width, img_height and max_iterations; col=0, row=0, pt_x=x_min, pt_y=y_max; busy=1; next state ISSUE.
REQ-022 In IDLE with start=1 and img_width=0 or img_height=0: stay IDLE, busy stays 0, frame_done=1 in the next cycle, no pt_req and no pixels.
REQ-023 In ISSUE, pt_req SHALL be 1 and pt_x/pt_y SHALL be stable; on pt_ack=1, pt_req=0 from the next cycle and the next state SHALL be WAIT.
REQ-024 pt_req SHALL be 1 exactly from the cycle after entering ISSUE until the cycle after pt_ack, and never in any other state.
REQ-025 In WAIT, pt_done=1 SHALL capture pt_iteration_count into pix_iterations, col into pix_col and row into pix_row; the next state SHALL be EMIT. pt_done SHALL be ignored outside WAIT.
REQ-026 In EMIT, pix_valid SHALL be 1 and the payload SHALL be held until pix_valid and pix_ready are both 1.
REQ-027 On the EMIT transfer, when col<img_width-1: col+=1, pt_x+=step, next state ISSUE.
REQ-028 On the EMIT transfer at end of row, when col=img_width-1 and row<img_height-1: col=0, row+=1, pt_x=x_min, pt_y-=step, next state ISSUE.
REQ-029 On the EMIT transfer at the last pixel (col=img_width-1, row=img_height-1): next state IDLE, busy=0, and frame_done=1 for exactly the next cycle.
REQ-030 Coordinate add and subtract SHALL be 32-bit two's complement and wrap silently.
REQ-031 start SHALL be ignored while busy=1; input changes SHALL not affect an in-progress frame.
REQ-032 Pixels SHALL be emitted in raster order, row-major, with exactly img_width*img_height transfers per frame.
REQ-033 Minimum per-pixel overhead beyond the point engine: 1 cycle pt_ack to WAIT, 1 cycle pt_done to pix_valid, 1 cycle transfer to new pt_req.

Reset
REQ-034 On reset=1 at a clock edge: state=IDLE; pt_req, pix_valid, busy, frame_done=0; col, row, pix_col, pix_row, pix_iterations=0.
REQ-035 Reset mid-frame SHALL abort the frame with no frame_done; the point engine SHALL share the same reset.

Verification
REQ-036 2x2 frame, x_min=0xC0000000 (-2.0), y_max=0x20000000 (1.0), step=0x10000000 (0.5) -> pt_x/pt_y sequence (-2.0,1.0), (-1.5,1.0), (-2.0,0.5), (-1.5,0.5); pixels (0,0), (1,0), (0,1), (1,1); one frame_done.
REQ-037 Stub engine returns count 37 after 5 cycles; pix_ready held low 4 cycles -> pix_valid and payload stable for 4 cycles; no new pt_req until the transfer.
REQ-038 img_width=0, start=1 -> frame_done pulses once, busy never 1, no pt_req.
REQ-039 start pulsed again mid-frame -> ignored; total pixel count still img_width*img_height.
REQ-040 Reset asserted while in WAIT -> all outputs 0 next cycle; a fresh start afterwards produces a full, correct frame.
REQ-041 max_iterations=100 -> pt_max_iterations=100 throughout the frame, unchanged if the input changes mid-frame.
